// File: rtl/fetch_if.sv
// Handshake bundle between the fetch stage, the instruction ROM and the control unit.
// The fetch unit uses the master view; the ROM/control side uses the slave view.
interface fetch_if #(
    parameter int ADDR_W = 15
);
    logic              set_pc;
    logic [15:0]       jump_addr;
    logic              instr_ready;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_req;
    logic              rom_ack;
    logic [15:0]       rom_data;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [15:0]       pc;

    modport master (
        input  set_pc, jump_addr, instr_ready, rom_ack, rom_data,
        output rom_addr, rom_req, instr, instr_valid, pc
    );

    modport slave (
        output set_pc, jump_addr, instr_ready, rom_ack, rom_data,
        input  rom_addr, rom_req, instr, instr_valid, pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a variable-latency ROM req/ack
// handshake and presents instructions with valid/ready; set_pc redirects fetch.
module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          ADDR_W       = 15
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR[ADDR_W-1:0];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_req_q, rom_req_d;
    logic [15:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [15:0]       pc_q, pc_d;

    logic [ADDR_W-1:0] jump_target;
    logic              unused_jump_bits;

    assign jump_target      = bus.jump_addr[ADDR_W-1:0];
    assign unused_jump_bits = ^bus.jump_addr;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        target_d      = target_q;
        rom_addr_d    = rom_addr_q;
        rom_req_d     = rom_req_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_d          = pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d   = ST_REQ;
                rom_req_d = 1'b1;
                if (bus.set_pc) begin
                    fetch_pc_d = jump_target;
                    rom_addr_d = jump_target;
                end else begin
                    rom_addr_d = fetch_pc_q;
                end
            end
            ST_REQ: begin
                if (bus.rom_ack) begin
                    if (bus.set_pc) begin
                        // Data belongs to the pre-redirect stream: drop it and reissue at the target.
                        rom_addr_d = jump_target;
                    end else begin
                        instr_d       = bus.rom_data;
                        pc_d          = 16'(rom_addr_q);
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = rom_addr_q + ADDR_W'(1);
                        rom_req_d     = 1'b0;
                        state_d       = ST_HOLD;
                    end
                end else if (bus.set_pc) begin
                    target_d = jump_target;
                    state_d  = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (bus.set_pc) begin
                    target_d = jump_target;
                end
                // The stale request must complete before the address may change.
                if (bus.rom_ack) begin
                    rom_addr_d = bus.set_pc ? jump_target : target_q;
                    state_d    = ST_REQ;
                end
            end
            default: begin
                if (bus.set_pc || bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    rom_req_d     = 1'b1;
                    rom_addr_d    = bus.set_pc ? jump_target : fetch_pc_q;
                    state_d       = ST_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            target_q      <= RESET_PC;
            rom_addr_q    <= RESET_PC;
            rom_req_q     <= 1'b0;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            pc_q          <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            target_q      <= target_d;
            rom_addr_q    <= rom_addr_d;
            rom_req_q     <= rom_req_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_q          <= pc_d;
        end
    end

    assign bus.rom_addr    = rom_addr_q;
    assign bus.rom_req     = rom_req_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model with programmable ack latency,
// scenario tasks with inline comparisons against hand-computed values.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   rom_lat = 0;
    int   wait_cnt = 0;
    logic ack_force = 1'b0;
    bit   req_seen [0:32767];

    fetch_if #(.ADDR_W(15)) bus ();

    fetch_unit #(
        .RESET_VECTOR(16'h0000),
        .ADDR_W      (15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // ROM model: acks after rom_lat wait cycles, data = addr ^ A5A5.
    assign bus.rom_ack  = ack_force | (bus.rom_req && (wait_cnt == rom_lat));
    assign bus.rom_data = 16'(bus.rom_addr) ^ 16'hA5A5;

    always @(posedge clk) begin
        if (!bus.rom_req || bus.rom_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
        if (bus.rom_req) req_seen[bus.rom_addr] <= 1'b1;
        if (bus.rom_req && bus.rom_ack)
            $display("[%0t] rom ack addr=%h data=%h set_pc=%b", $time, bus.rom_addr, bus.rom_data, bus.set_pc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.set_pc      = 1'b0;
        bus.jump_addr   = 16'h0000;
        bus.instr_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus.rom_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got=%h exp=0000", bus.instr); end
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got=%h exp=0000", bus.pc); end
        checks++; if (bus.rom_addr !== 15'h0000) begin errors++; $display("FAIL rst_addr got=%h exp=0000", bus.rom_addr); end
        rst = 1'b0;
        #2;
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", bus.rom_req); end
    endtask

    task automatic test_zero_wait();
        rom_lat = 0;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL zw_req[%0d] got=%b exp=1", i, bus.rom_req); end
            checks++; if (bus.rom_addr !== 15'(i)) begin errors++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, bus.rom_addr, i); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL zw_gap_valid[%0d] got=%b exp=0", i, bus.instr_valid); end
            tick();
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, bus.instr_valid); end
            checks++; if (bus.instr !== (16'(i) ^ 16'hA5A5)) begin errors++; $display("FAIL zw_instr[%0d] got=%h exp=%h", i, bus.instr, 16'(i) ^ 16'hA5A5); end
            checks++; if (bus.pc !== 16'(i)) begin errors++; $display("FAIL zw_pc[%0d] got=%h exp=%h", i, bus.pc, i); end
            checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL zw_hold_req[%0d] got=%b exp=0", i, bus.rom_req); end
        end
    endtask

    task automatic test_latency();
        rom_lat = 2;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL lat_req[%0d] got=%b exp=1", k, bus.rom_req); end
            checks++; if (bus.rom_addr !== 15'h0003) begin errors++; $display("FAIL lat_addr[%0d] got=%h exp=0003", k, bus.rom_addr); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_early[%0d] got=%b exp=0", k, bus.instr_valid); end
        end
        tick();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", bus.instr_valid); end
        checks++; if (bus.instr !== 16'hA5A6) begin errors++; $display("FAIL lat_instr got=%h exp=a5a6", bus.instr); end
        checks++; if (bus.pc !== 16'h0003) begin errors++; $display("FAIL lat_pc got=%h exp=0003", bus.pc); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, bus.instr_valid); end
            checks++; if (bus.instr !== 16'hA5A6) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=a5a6", k, bus.instr); end
            checks++; if (bus.pc !== 16'h0003) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=0003", k, bus.pc); end
            checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got=%b exp=0", k, bus.rom_req); end
        end
        bus.instr_ready = 1'b1;
        rom_lat = 0;
        tick();
        checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL resume_req got=%b exp=1", bus.rom_req); end
        checks++; if (bus.rom_addr !== 15'h0004) begin errors++; $display("FAIL resume_addr got=%h exp=0004", bus.rom_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL resume_valid got=%b exp=0", bus.instr_valid); end
    endtask

    task automatic test_jump_hold();
        tick();
        tick();
        tick();
        checks++; if (bus.pc !== 16'h0005) begin errors++; $display("FAIL jh_pc5 got=%h exp=0005", bus.pc); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL jh_valid5 got=%b exp=1", bus.instr_valid); end
        bus.set_pc      = 1'b1;
        bus.jump_addr   = 16'h0123;
        bus.instr_ready = 1'b0;
        tick();
        bus.set_pc      = 1'b0;
        bus.instr_ready = 1'b1;
        checks++; if (bus.rom_addr !== 15'h0123) begin errors++; $display("FAIL jh_addr got=%h exp=0123", bus.rom_addr); end
        checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL jh_req got=%b exp=1", bus.rom_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL jh_drop got=%b exp=0", bus.instr_valid); end
        tick();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL jh_tvalid got=%b exp=1", bus.instr_valid); end
        checks++; if (bus.pc !== 16'h0123) begin errors++; $display("FAIL jh_tpc got=%h exp=0123", bus.pc); end
        checks++; if (bus.instr !== 16'hA486) begin errors++; $display("FAIL jh_tinstr got=%h exp=a486", bus.instr); end
        checks++; if (req_seen[6] !== 1'b0) begin errors++; $display("FAIL jh_addr6_fetched got=%b exp=0", req_seen[6]); end
    endtask

    task automatic test_redirect_in_req();
        rom_lat       = 2;
        bus.set_pc    = 1'b1;
        bus.jump_addr = 16'h0003;
        tick();
        checks++; if (bus.rom_addr !== 15'h0003) begin errors++; $display("FAIL rr_addr3 got=%h exp=0003", bus.rom_addr); end
        bus.jump_addr = 16'h0040;
        tick();
        bus.set_pc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.rom_addr !== 15'h0003) begin errors++; $display("FAIL rr_old_addr[%0d] got=%h exp=0003", k, bus.rom_addr); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rr_old_valid[%0d] got=%b exp=0", k, bus.instr_valid); end
            tick();
        end
        checks++; if (bus.rom_addr !== 15'h0040) begin errors++; $display("FAIL rr_new_addr got=%h exp=0040", bus.rom_addr); end
        checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL rr_new_req got=%b exp=1", bus.rom_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rr_stale_valid got=%b exp=0", bus.instr_valid); end
        tick();
        tick();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rr_wait_valid got=%b exp=0", bus.instr_valid); end
        tick();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rr_valid got=%b exp=1", bus.instr_valid); end
        checks++; if (bus.pc !== 16'h0040) begin errors++; $display("FAIL rr_pc got=%h exp=0040", bus.pc); end
        checks++; if (bus.instr !== 16'hA5E5) begin errors++; $display("FAIL rr_instr got=%h exp=a5e5", bus.instr); end
    endtask

    task automatic test_wrap();
        rom_lat       = 0;
        bus.set_pc    = 1'b1;
        bus.jump_addr = 16'h7FFF;
        tick();
        bus.set_pc = 1'b0;
        checks++; if (bus.rom_addr !== 15'h7FFF) begin errors++; $display("FAIL wr_addr got=%h exp=7fff", bus.rom_addr); end
        tick();
        checks++; if (bus.pc !== 16'h7FFF) begin errors++; $display("FAIL wr_pc got=%h exp=7fff", bus.pc); end
        checks++; if (bus.instr !== 16'hDA5A) begin errors++; $display("FAIL wr_instr got=%h exp=da5a", bus.instr); end
        tick();
        checks++; if (bus.rom_addr !== 15'h0000) begin errors++; $display("FAIL wr_next_addr got=%h exp=0000", bus.rom_addr); end
        checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL wr_next_req got=%b exp=1", bus.rom_req); end
    endtask

    task automatic test_async_reset();
        rom_lat = 5;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.rom_req !== 1'b0) begin errors++; $display("FAIL ar_req got=%b exp=0", bus.rom_req); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", bus.instr_valid); end
        checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL ar_instr got=%h exp=0000", bus.instr); end
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL ar_pc got=%h exp=0000", bus.pc); end
        checks++; if (bus.rom_addr !== 15'h0000) begin errors++; $display("FAIL ar_addr got=%h exp=0000", bus.rom_addr); end
        ack_force = 1'b1;
        tick();
        tick();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_late_ack got=%b exp=0", bus.instr_valid); end
        rst = 1'b0;
        tick();
        ack_force = 1'b0;
        rom_lat   = 0;
        checks++; if (bus.rom_req !== 1'b1) begin errors++; $display("FAIL ar_restart_req got=%b exp=1", bus.rom_req); end
        checks++; if (bus.rom_addr !== 15'h0000) begin errors++; $display("FAIL ar_restart_addr got=%h exp=0000", bus.rom_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL ar_restart_valid got=%b exp=0", bus.instr_valid); end
        tick();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL ar_first_valid got=%b exp=1", bus.instr_valid); end
        checks++; if (bus.instr !== 16'hA5A5) begin errors++; $display("FAIL ar_first_instr got=%h exp=a5a5", bus.instr); end
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL ar_first_pc got=%h exp=0000", bus.pc); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_hold_stall();
        test_jump_hold();
        test_redirect_in_req();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
